reset_request_gen: RTL



---
 rtl/reset_request_gen.sv | 114 +++++++++++
 1 files changed

// File: rtl/reset_request_gen.sv
// Reset request generator: merges power-on, software handshake and watchdog
// sources into one stretched, flop-driven active-low reset request.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_ASSERT  | rst_req_n held low, cnt counts to PULSE_CYCLES-1
// ST_HOLDOFF | rst_req_n released, requests ignored until HOLDOFF_CYCLES pass
// ST_IDLE    | waiting for a software request or a watchdog expiry
module reset_request_gen #(
    parameter int PULSE_CYCLES   = 16,
    parameter int HOLDOFF_CYCLES = 8,
    parameter int WDT_WIDTH      = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sw_req,
    output logic                 sw_ack,
    input  logic                 wdt_en,
    input  logic                 wdt_kick,
    input  logic [WDT_WIDTH-1:0] wdt_limit,
    output logic                 rst_req_n,
    output logic                 busy,
    output logic [1:0]           cause
);

    localparam int CNT_MAX = (PULSE_CYCLES > HOLDOFF_CYCLES) ? PULSE_CYCLES : HOLDOFF_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'b00,
        ST_HOLDOFF = 2'b01,
        ST_IDLE    = 2'b10
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [WDT_WIDTH-1:0] wdt_cnt;

    logic in_idle;
    logic sw_trig;
    logic wdt_expire;
    logic trigger;

    // A kick in the expiry cycle suppresses the expiry.
    always_comb begin
        in_idle    = (state == ST_IDLE);
        sw_trig    = in_idle && sw_req && !sw_ack;
        wdt_expire = in_idle && wdt_en && (wdt_limit != '0) && !wdt_kick &&
                     (wdt_cnt == (wdt_limit - WDT_WIDTH'(1)));
        trigger    = sw_trig || wdt_expire;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_ASSERT;
            cnt       <= '0;
            rst_req_n <= 1'b0;
            busy      <= 1'b1;
            sw_ack    <= 1'b0;
            cause     <= 2'b00;
            wdt_cnt   <= '0;
        end else begin
            if (sw_trig)
                sw_ack <= 1'b1;
            else if (sw_ack && !sw_req)
                sw_ack <= 1'b0;

            // Watchdog only runs in IDLE; a zero limit freezes it in place.
            if (!in_idle || !wdt_en || wdt_kick || trigger)
                wdt_cnt <= '0;
            else if (wdt_limit != '0)
                wdt_cnt <= wdt_cnt + WDT_WIDTH'(1);

            case (state)
                ST_ASSERT: begin
                    if (cnt == PULSE_LAST) begin
                        state     <= ST_HOLDOFF;
                        cnt       <= '0;
                        rst_req_n <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (cnt == HOLD_LAST) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_IDLE: begin
                    if (trigger) begin
                        state     <= ST_ASSERT;
                        cnt       <= '0;
                        rst_req_n <= 1'b0;
                        busy      <= 1'b1;
                        cause     <= {wdt_expire, sw_trig};
                    end
                end
                default: begin
                    state     <= ST_ASSERT;
                    cnt       <= '0;
                    rst_req_n <= 1'b0;
                    busy      <= 1'b1;
                end
            endcase
        end
    end

endmodule
